// File: rtl/fsweep_pkg.sv
// Shared types and constants for the formula sweep driver.
// The LFSR tap table is only referenced when FSWEEP_LFSR_EN is defined.
package fsweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } fsweep_state_t;

  localparam int unsigned FSWEEP_MAX_W = 64;

  // Galois right-shift feedback masks for maximal-length sequences; bit (t-1) set for tap t.
  localparam logic [63:0] FSWEEP_LFSR_TAPS [0:64] = '{
    64'h0,                  64'h0,                  64'h3,                  64'h6,
    64'hC,                  64'h14,                 64'h30,                 64'h60,
    64'hB8,                 64'h110,                64'h240,                64'h500,
    64'h829,                64'h100D,               64'h2015,               64'h6000,
    64'hD008,               64'h12000,              64'h20400,              64'h40023,
    64'h90000,              64'h140000,             64'h300000,             64'h420000,
    64'hE10000,             64'h1200000,            64'h2000023,            64'h4000013,
    64'h9000000,            64'h14000000,           64'h20000029,           64'h48000000,
    64'h80200003,           64'h1_0008_0000,        64'h2_0400_0003,        64'h5_0000_0000,
    64'h8_0100_0000,        64'h10_0000_001F,       64'h20_0000_0031,       64'h44_0000_0000,
    64'hA0_0014_0000,       64'h120_0000_0000,      64'h300_000C_0000,      64'h630_0000_0000,
    64'hC00_0003_0000,      64'h1B00_0000_0000,     64'h3000_0300_0000,     64'h4200_0000_0000,
    64'hC000_0018_0000,     64'h1_0080_0000_0000,   64'h3_0000_00C0_0000,   64'h6_000C_0000_0000,
    64'h9_0000_0000_0000,   64'h18_0030_0000_0000,  64'h30_0000_0003_0000,  64'h40_0000_4000_0000,
    64'hC0_0006_0000_0000,  64'h102_0000_0000_0000, 64'h200_0040_0000_0000, 64'h600_0030_0000_0000,
    64'hC00_0000_0000_0000, 64'h1800_3000_0000_0000, 64'h3000_0000_0000_0030, 64'h6000_0000_0000_0000,
    64'hD800_0000_0000_0000
  };

  function automatic logic [63:0] all_ones(input int unsigned w);
    logic [63:0] r;
    if (w >= FSWEEP_MAX_W) begin
      r = {64{1'b1}};
    end else begin
      r = (64'd1 << w) - 64'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fsweep_next_vec.sv
// Next-assignment generator: binary incrementer by default, Galois LFSR when
// FSWEEP_LFSR_EN is defined (then is_last flags the step that returns to first_vec).
module fsweep_next_vec
  import fsweep_pkg::*;
#(
  parameter int unsigned N_IN = 61
) (
  input  logic [N_IN-1:0] cur,
`ifdef FSWEEP_LFSR_EN
  input  logic [N_IN-1:0] first_vec,
`endif
  output logic [N_IN-1:0] nxt,
  output logic            is_last
);

`ifdef FSWEEP_LFSR_EN
  localparam logic [63:0]     TAPS64 = FSWEEP_LFSR_TAPS[N_IN];
  localparam logic [N_IN-1:0] MASK   = TAPS64[N_IN-1:0];

  always_comb begin
    nxt     = {1'b0, cur[N_IN-1:1]} ^ (cur[0] ? MASK : {N_IN{1'b0}});
    is_last = (nxt == first_vec);
  end
`else
  localparam logic [63:0]     ONES64 = all_ones(N_IN);
  localparam logic [N_IN-1:0] ONES   = ONES64[N_IN-1:0];

  always_comb begin
    nxt     = cur + {{(N_IN-1){1'b0}}, 1'b1};
    is_last = (cur == ONES);
  end
`endif

endmodule

// File: rtl/formula_sweep_driver.sv
// Sweeps formula input assignments two cycles each and stops on the first o_1=0.
// Define FSWEEP_LFSR_EN to step through an LFSR sequence instead of counting.
module formula_sweep_driver
  import fsweep_pkg::*;
#(
  parameter int unsigned N_IN  = 61,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [N_IN-1:0]  start_vec,
  input  logic [CNT_W-1:0] max_count,
  output logic [N_IN-1:0]  vec_o,
  output logic             vec_valid,
  input  logic             f_in,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic             wrapped,
  output logic [N_IN-1:0]  cex_vec,
  output logic [CNT_W-1:0] tested_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  fsweep_state_t    state_q, state_d;
  logic [N_IN-1:0]  vec_q, vec_d;
  logic [N_IN-1:0]  cex_q, cex_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] budget_q, budget_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;
  logic             wrapped_q, wrapped_d;
  logic [N_IN-1:0]  load_vec_s;
  logic [N_IN-1:0]  nxt_s;
  logic             is_last_s;
  logic [CNT_W-1:0] cnt_inc_s;

`ifdef FSWEEP_LFSR_EN
  logic [N_IN-1:0]  first_q, first_d;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  assign load_vec_s = (start_vec == {N_IN{1'b0}}) ? {{(N_IN-1){1'b0}}, 1'b1} : start_vec;
`else
  assign load_vec_s = start_vec;
`endif

  assign cnt_inc_s = cnt_q + CNT_ONE;

  fsweep_next_vec #(.N_IN(N_IN)) u_next (
    .cur       (vec_q),
`ifdef FSWEEP_LFSR_EN
    .first_vec (first_q),
`endif
    .nxt       (nxt_s),
    .is_last   (is_last_s)
  );

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    cex_d     = cex_q;
    cnt_d     = cnt_q;
    budget_d  = budget_q;
    fail_d    = fail_q;
    wrapped_d = wrapped_q;
`ifdef FSWEEP_LFSR_EN
    first_d   = first_q;
`endif
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          fail_d    = 1'b0;
          wrapped_d = 1'b0;
          cnt_d     = {CNT_W{1'b0}};
          budget_d  = max_count;
`ifdef FSWEEP_LFSR_EN
          first_d   = load_vec_s;
`endif
          if (max_count == {CNT_W{1'b0}}) begin
            state_d = DONE;
          end else begin
            vec_d   = load_vec_s;
            state_d = DRIVE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      DRIVE: state_d = CHECK;
      CHECK: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_inc_s;
        // Falsification outranks budget exhaustion, which outranks wrap-around.
        if (!f_in) begin
          fail_d  = 1'b1;
          cex_d   = vec_q;
          state_d = DONE;
        end else if (cnt_inc_s == budget_q) begin
          state_d = DONE;
        end else if (is_last_s) begin
          wrapped_d = 1'b1;
          state_d   = DONE;
        end else begin
          vec_d   = nxt_s;
          state_d = DRIVE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d   = IDLE;
      fail_d    = 1'b0;
      wrapped_d = 1'b0;
      cex_d     = {N_IN{1'b0}};
      cnt_d     = {CNT_W{1'b0}};
    end else begin
      state_d = state_d;
    end

    if ((state_d == IDLE) || (state_d == DONE)) begin
      vec_d = {N_IN{1'b0}};
    end else begin
      vec_d = vec_d;
    end

    valid_d = (state_d == DRIVE) || (state_d == CHECK);
    busy_d  = valid_d;
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      vec_q     <= {N_IN{1'b0}};
      cex_q     <= {N_IN{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      budget_q  <= {CNT_W{1'b0}};
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
      wrapped_q <= 1'b0;
`ifdef FSWEEP_LFSR_EN
      first_q   <= {N_IN{1'b0}};
`endif
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      cex_q     <= cex_d;
      cnt_q     <= cnt_d;
      budget_q  <= budget_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
      wrapped_q <= wrapped_d;
`ifdef FSWEEP_LFSR_EN
      first_q   <= first_d;
`endif
    end
  end

  assign vec_o        = vec_q;
  assign vec_valid    = valid_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign fail         = fail_q;
  assign wrapped      = wrapped_q;
  assign cex_vec      = cex_q;
  assign tested_count = cnt_q;

endmodule
